filter_pass_sequencer: RTL and testbench

FILTER_PASS_SEQUENCER -- requirements
Module: filter_pass_sequencer

---
 rtl/filter_pass_sequencer.sv | 113 +++++++++++
 tb/tb_filter_pass_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_pass_sequencer.sv
// Sequences a multi-pass separable filter over one frame: starts the read/write
// engine once per pass, alternating direction, and reports done or a start timeout.
module filter_pass_sequencer #(
  parameter int PASS_W        = 3,
  parameter int START_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seq_start,
  input  logic              seq_index,
  input  logic [PASS_W-1:0] cfg_passes,
  output logic              seq_idle,
  output logic              seq_done,
  output logic              seq_error,
  output logic              rw_start,
  output logic              rw_index,
  output logic [PASS_W-1:0] rw_pass,
  output logic              rw_vertical,
  input  logic              rw_idle
);

  localparam int TO_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

  // Handshake: rw_start is a level request held while the engine still reports
  // idle; the engine accepts by dropping rw_idle, and finishes by raising it again.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_START_PASS = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] count_q, count_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              index_q, index_d;
  logic              error_q, error_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state;
    pass_d  = pass_q;
    count_d = count_q;
    to_d    = '0;
    index_d = index_q;
    error_d = error_q;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (seq_start) begin
          index_d = seq_index;
          count_d = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
          pass_d  = '0;
          error_d = 1'b0;
          state_d = ST_START_PASS;
        end
      end
      ST_START_PASS: begin
        if (!rw_idle) begin
          state_d = ST_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (rw_idle) begin
          // Last pass compares against count-1, so rw_pass never wraps.
          if (pass_q == count_q - PASS_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            state_d = ST_START_PASS;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pass_q  <= '0;
      count_q <= PASS_W'(1);
      to_q    <= '0;
      index_q <= 1'b0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      pass_q  <= pass_d;
      count_q <= count_d;
      to_q    <= to_d;
      index_q <= index_d;
      error_q <= error_d;
      done_q  <= done_d;
    end
  end

  assign seq_idle    = (state == ST_IDLE);
  assign rw_start    = (state == ST_START_PASS);
  assign seq_done    = done_q;
  assign seq_error   = error_q;
  assign rw_index    = index_q;
  assign rw_pass     = pass_q;
  assign rw_vertical = pass_q[0];

endmodule

// File: tb/tb_filter_pass_sequencer.sv
// Bench for filter_pass_sequencer: frames are planned as per-cycle timelines
// (engine behaviour plus expected outputs) and replayed against the DUT.
module tb_filter_pass_sequencer;

  localparam int PW = 3;
  localparam int TO = 16;
  localparam int EW = 6 + PW;
  localparam int K_IDLE = 0, K_START = 1, K_WAIT = 2;

  logic          clk, reset, seq_start, seq_index, rw_idle;
  logic [PW-1:0] cfg_passes;
  logic          seq_idle, seq_done, seq_error, rw_start, rw_index, rw_vertical;
  logic [PW-1:0] rw_pass;

  filter_pass_sequencer #(.PASS_W(PW), .START_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .seq_start(seq_start), .seq_index(seq_index),
    .cfg_passes(cfg_passes), .seq_idle(seq_idle), .seq_done(seq_done),
    .seq_error(seq_error), .rw_start(rw_start), .rw_index(rw_index),
    .rw_pass(rw_pass), .rw_vertical(rw_vertical), .rw_idle(rw_idle)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          chk;
    logic          rst;
    logic          st;
    logic          idx;
    logic [PW-1:0] cfg;
    logic          rwi;
  } stim_t;

  stim_t         stim_q[$];
  logic [EW-1:0] exp_q[$];

  // frame-level model of what the sequencer must be showing
  logic m_idx, m_err, m_done;
  int   m_pass, m_n;
  int   n_checks, n_pass;
  int   start_cycles, done_count, max_pass;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [PW-1:0] rcfg();
    return PW'($urandom_range(0, (1 << PW) - 1));
  endfunction

  function automatic logic stray(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 3) == 0);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pass = 0; m_idx = 1'b0; m_err = 1'b0; m_done = 1'b0; m_n = 1;
  endtask

  task automatic push(input int kind, input logic rst, input logic st, input logic idx,
                      input logic [PW-1:0] cfg, input logic rwi, input logic chk);
    logic e_idle, e_start, e_done;
    e_idle  = (kind == K_IDLE);
    e_start = (kind == K_START);
    e_done  = e_idle && m_done;
    if (e_idle) m_done = 1'b0;
    stim_q.push_back('{chk: chk, rst: rst, st: st, idx: idx, cfg: cfg, rwi: rwi});
    exp_q.push_back({e_idle, e_start, e_done, m_err, m_idx, 1'(m_pass % 2), PW'(m_pass)});
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) push(K_IDLE, 1'b0, 1'b0, rb(), rcfg(), rb(), 1'b1);
  endtask

  task automatic accept(input logic idx, input logic [PW-1:0] cfg);
    push(K_IDLE, 1'b0, 1'b1, idx, cfg, 1'b1, 1'b1);
    m_idx = idx; m_n = (cfg == 0) ? 1 : int'(cfg); m_pass = 0; m_err = 1'b0;
  endtask

  // engine takes the request after lat cycles, then stays busy busy+1 more cycles
  task automatic start_part(input int lat, input int mode);
    for (int j = 0; j <= lat; j++)
      push(K_START, 1'b0, stray(mode), rb(), rcfg(), (j < lat), 1'b1);
  endtask

  task automatic run_pass(input int lat, input int busy, input int mode);
    start_part(lat, mode);
    for (int j = 0; j < busy; j++) push(K_WAIT, 1'b0, stray(mode), rb(), rcfg(), 1'b0, 1'b1);
    push(K_WAIT, 1'b0, stray(mode), rb(), rcfg(), 1'b1, 1'b1);
    if (m_pass == m_n - 1) m_done = 1'b1;
    else m_pass++;
  endtask

  task automatic timeout_pass(input int mode);
    for (int j = 0; j < TO; j++) push(K_START, 1'b0, stray(mode), rb(), rcfg(), 1'b1, 1'b1);
    m_err = 1'b1;
  endtask

  task automatic reset_in_wait(input int lat, input int k, input int mode);
    start_part(lat, mode);
    for (int j = 0; j < k; j++) push(K_WAIT, 1'b0, stray(mode), rb(), rcfg(), 1'b0, 1'b1);
    push(K_WAIT, 1'b1, rb(), rb(), rcfg(), 1'b0, 1'b1);
    model_reset();
  endtask

  task automatic clr_obs();
    start_cycles = 0; done_count = 0; max_pass = 0;
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // scoreboard: replay the plan one cycle at a time and compare every output
  task automatic drain();
    stim_t         s;
    logic [EW-1:0] e, a;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      reset = s.rst; seq_start = s.st; seq_index = s.idx; cfg_passes = s.cfg; rw_idle = s.rwi;
      if (s.chk) begin
        a = {seq_idle, rw_start, seq_done, seq_error, rw_index, rw_vertical, rw_pass};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL outputs @%0t {idle,start,done,err,idx,vert,pass}: got %b expected %b",
                      $time, a, e);
      end
      if (rw_start === 1'b1) begin
        start_cycles++;
        if (int'(rw_pass) > max_pass) max_pass = int'(rw_pass);
      end
      if (seq_done === 1'b1) done_count++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n, r, tp, lat;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; seq_start = 1'b1; seq_index = 1'b0; cfg_passes = '0; rw_idle = 1'b1;
    model_reset();
    push(K_IDLE, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
    push(K_IDLE, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1);
    idle_cyc(2);
    drain();

    // two passes, index 1, engine busy 5 cycles each
    clr_obs(); accept(1'b1, 3'd2); run_pass(1, 4, 0); run_pass(1, 4, 0); idle_cyc(2); drain();
    check_lit("f1_start_cycles", start_cycles, 4);
    check_lit("f1_done_pulses", done_count, 1);
    check_lit("f1_last_pass", max_pass, 1);
    check_lit("f1_index", int'(rw_index), 1);

    // zero passes behaves as one
    clr_obs(); accept(1'b0, 3'd0); run_pass(1, 4, 0); idle_cyc(2); drain();
    check_lit("f2_start_cycles", start_cycles, 2);
    check_lit("f2_done_pulses", done_count, 1);
    check_lit("f2_last_pass", max_pass, 0);

    // engine never responds
    clr_obs(); accept(1'b0, 3'd3); timeout_pass(0); idle_cyc(3); drain();
    check_lit("f3_start_cycles", start_cycles, TO);
    check_lit("f3_done_pulses", done_count, 0);
    check_lit("f3_error", int'(seq_error), 1);
    check_lit("f3_idle", int'(seq_idle), 1);
    accept(1'b1, 3'd1); run_pass(0, 0, 0); idle_cyc(1); drain();
    check_lit("f3_error_cleared", int'(seq_error), 0);

    // restarts mid-frame are ignored
    clr_obs(); accept(1'b1, 3'd2); run_pass(2, 3, 2); run_pass(2, 3, 2); idle_cyc(2); drain();
    check_lit("f4_start_cycles", start_cycles, 6);
    check_lit("f4_last_pass", max_pass, 1);
    check_lit("f4_index", int'(rw_index), 1);

    // reset while waiting on pass 1
    clr_obs(); accept(1'b1, 3'd3); run_pass(0, 2, 0); reset_in_wait(1, 2, 0); idle_cyc(2); drain();
    check_lit("f5_done_pulses", done_count, 0);
    check_lit("f5_pass", int'(rw_pass), 0);
    check_lit("f5_index", int'(rw_index), 0);

    // back-to-back frames with seq_start held high
    clr_obs();
    accept(1'b0, 3'd1); run_pass(0, 1, 2);
    accept(1'b1, 3'd1); run_pass(0, 1, 2);
    accept(1'b0, 3'd1); run_pass(0, 1, 2);
    idle_cyc(2); drain();
    check_lit("f6_done_pulses", done_count, 3);
    check_lit("f6_index", int'(rw_index), 0);

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      idle_cyc($urandom_range(0, 3));
      accept(rb(), rcfg());
      n = m_n;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        tp = $urandom_range(0, n - 1);
        for (int p = 0; p < tp; p++) run_pass($urandom_range(0, 3), $urandom_range(0, 6), 1);
        timeout_pass(1);
      end else if (r == 1 && n >= 2) begin
        run_pass($urandom_range(0, 3), $urandom_range(0, 6), 1);
        reset_in_wait($urandom_range(0, 3), $urandom_range(0, 4), 1);
      end else begin
        for (int p = 0; p < n; p++) begin
          lat = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
          run_pass(lat, $urandom_range(0, 6), $urandom_range(0, 2));
        end
      end
      drain();
    end
    idle_cyc(2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
